// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// master: datapath side; slave: the hazard control unit.
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             ex_valid;
    logic [REG_W-1:0] ex_rd;
    logic             ex_is_load;
    logic             ex_is_mem;
    logic             ex_is_mul;
    logic             mem_ready;
    logic             br_taken;
    logic             stall_pc;
    logic             stall_ifid;
    logic             flush_ifid;
    logic             stall_idex;
    logic             flush_idex;
    logic             busy;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_valid, ex_rd, ex_is_load, ex_is_mem, ex_is_mul,
        output mem_ready, br_taken,
        input  stall_pc, stall_ifid, flush_ifid,
        input  stall_idex, flush_idex, busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_valid, ex_rd, ex_is_load, ex_is_mem, ex_is_mul,
        input  mem_ready, br_taken,
        output stall_pc, stall_ifid, flush_ifid,
        output stall_idex, flush_idex, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush generation for the IF -> ID -> EX pipeline: load-use,
// multi-cycle multiply, data-memory wait and taken-branch redirect.
module hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam bit               MUL_MULTI = (MUL_CYCLES > 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic             busy_q, busy_d;

    logic mem_hold;
    logic mul_hold;
    logic br_hit;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    assign mem_hold = hz.ex_valid & hz.ex_is_mem & ~hz.mem_ready;
    assign mul_hold = hz.ex_valid & hz.ex_is_mul & MUL_MULTI;
    assign br_hit   = hz.ex_valid & hz.br_taken;
    assign rs1_hit  = hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit  = hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd);
    assign load_use = hz.ex_valid & hz.ex_is_load
                    & (hz.ex_rd != '0) & (rs1_hit | rs2_hit);

    always_comb begin
        state_d        = state_q;
        mul_cnt_d      = mul_cnt_q;
        hz.stall_pc    = 1'b0;
        hz.stall_ifid  = 1'b0;
        hz.flush_ifid  = 1'b0;
        hz.stall_idex  = 1'b0;
        hz.flush_idex  = 1'b0;
        if (rst) begin
            state_d   = RUN;
            mul_cnt_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_hold) begin
                        hz.stall_pc   = 1'b1;
                        hz.stall_ifid = 1'b1;
                        hz.stall_idex = 1'b1;
                        state_d       = MEM_WAIT;
                    end else if (mul_hold) begin
                        hz.stall_pc   = 1'b1;
                        hz.stall_ifid = 1'b1;
                        hz.stall_idex = 1'b1;
                        mul_cnt_d     = CNT_W'(1);
                        state_d       = MUL_BUSY;
                    end else if (br_hit) begin
                        hz.flush_ifid = 1'b1;
                        hz.flush_idex = 1'b1;
                    end else if (load_use) begin
                        // Hold the consumer in ID and send one bubble down.
                        hz.stall_pc   = 1'b1;
                        hz.stall_ifid = 1'b1;
                        hz.flush_idex = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt_q == MUL_LAST) begin
                        mul_cnt_d = '0;
                        state_d   = RUN;
                    end else begin
                        hz.stall_pc   = 1'b1;
                        hz.stall_ifid = 1'b1;
                        hz.stall_idex = 1'b1;
                        mul_cnt_d     = mul_cnt_q + CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        state_d = RUN;
                    end else begin
                        hz.stall_pc   = 1'b1;
                        hz.stall_ifid = 1'b1;
                        hz.stall_idex = 1'b1;
                    end
                end
                default: begin
                    state_d   = RUN;
                    mul_cnt_d = '0;
                end
            endcase
        end
        busy_d = (state_d != RUN);
    end

    assign hz.busy = busy_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cycles push expected
// outputs, an independent monitor pops and compares every cycle.
module tb_hazard_ctrl;
    localparam int REG_W = 5;

    // {stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex, busy}
    localparam logic [5:0] IDLE  = 6'b000000;
    localparam logic [5:0] STALL = 6'b110100;
    localparam logic [5:0] STALB = 6'b110101;
    localparam logic [5:0] LU    = 6'b110010;
    localparam logic [5:0] BR    = 6'b001010;
    localparam logic [5:0] BONLY = 6'b000001;

    logic clk;
    logic rst;

    hazard_ctrl_if #(.REG_W(REG_W)) hz ();

    hazard_ctrl #(
        .REG_W(REG_W),
        .MUL_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] exp_q[$];
    string      tag_q[$];
    int         vectors;
    int         miscompares;
    bit         stim_done;

    initial begin
        vectors     = 0;
        miscompares = 0;
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [5:0] act;
            logic [5:0] exp;
            string      tag;
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            act = {hz.stall_pc, hz.stall_ifid, hz.flush_ifid,
                   hz.stall_idex, hz.flush_idex, hz.busy};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b", tag, act, exp);
            end
        end
    end

    task automatic clr();
        hz.id_rs1      = '0;
        hz.id_rs2      = '0;
        hz.id_rs1_used = 1'b0;
        hz.id_rs2_used = 1'b0;
        hz.ex_valid    = 1'b0;
        hz.ex_rd       = '0;
        hz.ex_is_load  = 1'b0;
        hz.ex_is_mem   = 1'b0;
        hz.ex_is_mul   = 1'b0;
        hz.mem_ready   = 1'b0;
        hz.br_taken    = 1'b0;
    endtask

    task automatic cyc(input logic [5:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic load_hit(input logic [4:0] rd, input logic [4:0] rs);
        clr();
        hz.ex_valid    = 1'b1;
        hz.ex_is_load  = 1'b1;
        hz.ex_rd       = rd;
        hz.id_rs2      = rs;
        hz.id_rs2_used = 1'b1;
    endtask

    task automatic mul_in();
        clr();
        hz.ex_valid  = 1'b1;
        hz.ex_is_mul = 1'b1;
    endtask

    task automatic mem_in(input logic rdy);
        clr();
        hz.ex_valid  = 1'b1;
        hz.ex_is_mem = 1'b1;
        hz.mem_ready = rdy;
    endtask

    initial begin
        stim_done = 1'b0;
        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;
        // Reset masks everything, even live hazards.
        mem_in(1'b0);
        hz.br_taken = 1'b1;
        cyc(IDLE, "rst_mask0");
        cyc(IDLE, "rst_mask1");
        rst = 1'b0;
        clr();
        cyc(IDLE, "idle");

        load_hit(5'd5, 5'd5);
        cyc(LU, "lu_rs2");
        clr();
        cyc(IDLE, "lu_clear");
        load_hit(5'd0, 5'd0);
        cyc(IDLE, "lu_x0");
        load_hit(5'd5, 5'd5);
        hz.id_rs2_used = 1'b0;
        cyc(IDLE, "lu_unused");
        clr();
        hz.ex_valid    = 1'b1;
        hz.ex_is_load  = 1'b1;
        hz.ex_rd       = 5'd7;
        hz.id_rs1      = 5'd7;
        hz.id_rs1_used = 1'b1;
        cyc(LU, "lu_rs1");
        hz.ex_rd = 5'd23;
        cyc(IDLE, "lu_msb_diff");
        hz.ex_valid = 1'b0;
        hz.ex_rd    = 5'd7;
        cyc(IDLE, "lu_bubble");

        mul_in();
        cyc(STALL, "mul1_c1");
        cyc(STALB, "mul1_c2");
        hz.br_taken = 1'b1;
        cyc(STALB, "mul1_c3_br");
        hz.br_taken = 1'b0;
        cyc(BONLY, "mul1_c4");
        cyc(STALL, "mul2_c1");
        cyc(STALB, "mul2_c2");
        cyc(STALB, "mul2_c3");
        cyc(BONLY, "mul2_c4");
        clr();
        cyc(IDLE, "mul_after");

        mem_in(1'b0);
        cyc(STALL, "mem_c1");
        cyc(STALB, "mem_c2");
        hz.br_taken    = 1'b1;
        hz.ex_is_load  = 1'b1;
        hz.ex_rd       = 5'd9;
        hz.id_rs1      = 5'd9;
        hz.id_rs1_used = 1'b1;
        cyc(STALB, "mem_c3_br");
        mem_in(1'b0);
        cyc(STALB, "mem_c4");
        cyc(STALB, "mem_c5");
        hz.mem_ready = 1'b1;
        cyc(BONLY, "mem_done");
        clr();
        cyc(IDLE, "mem_after");
        mem_in(1'b1);
        cyc(IDLE, "mem_fast");
        clr();
        cyc(IDLE, "mem_fast_after");

        load_hit(5'd5, 5'd5);
        hz.br_taken = 1'b1;
        cyc(BR, "br_over_lu");
        hz.ex_valid = 1'b0;
        cyc(IDLE, "br_no_valid");

        mul_in();
        cyc(STALL, "rmul_c1");
        cyc(STALB, "rmul_c2");
        rst = 1'b1;
        cyc(IDLE, "rmul_rst");
        rst = 1'b0;
        cyc(STALL, "rmul2_c1");
        cyc(STALB, "rmul2_c2");
        cyc(STALB, "rmul2_c3");
        cyc(BONLY, "rmul2_c4");

        mem_in(1'b0);
        cyc(STALL, "rmem_c1");
        cyc(STALB, "rmem_c2");
        rst = 1'b1;
        cyc(IDLE, "rmem_rst");
        rst = 1'b0;
        clr();
        cyc(IDLE, "rmem_after");
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
